imem_responder: RTL and testbench
=================================

# imem_responder

Responder side of the processor's instruction-memory fetch interface. It accepts fetch requests (`in_mem_addr`, `in_mem_en`) and returns `in_mem` after a programmable number of wait states, with a valid/busy handshake. It holds a word-addressed instruction RAM and a preload port, so benches and boot logic can load a program before releasing the core. It sits beside the core top level, driving the core's `in_mem` input.

## Interface

**Parameters**
- `DEPTH`, default 1024: number of 32-bit words; must be a power of two, at most 65536.
- `LATENCY`, default 2: wait cycles between acceptance and response; legal range 0..15.

**Ports**
- `clk`  in  1  main clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_mem_addr`  in  32  byte address of the fetch.
- `in_mem_en`  in  1  fetch request.
- `in_mem`  out  32  fetched instruction word.
- `in_mem_valid`  out  1  `in_mem` is valid this cycle; a one-cycle pulse per request.
- `in_mem_busy`  out  1  a request is in flight; new requests are ignored.
- `in_mem_fault`  out  1  the response is a fault; asserted only together with `in_mem_valid`.
- `load_en`  in  1  preload write strobe.
- `load_addr`  in  32  byte address of the preload word.
- `load_data`  in  32  preload word.

## Operation

**States**
- **IDLE:** no request in flight.
  - `in_mem_en=1` → accept the request, then go to WAIT if `LATENCY>0`, otherwise to RESP.
- **WAIT:** counting down wait cycles.
  - The counter is loaded with `LATENCY-1` at acceptance and decrements each cycle.
  - At 0 → RESP.
  - `in_mem_en` is ignored in this state.
- **RESP:** `in_mem_valid=1` for this cycle.
  - `in_mem_en=1` → accept the next request in the same cycle, then go to WAIT or RESP as above.
  - Otherwise → IDLE.

**Acceptance**
- The word index `in_mem_addr[31:2]` is compared against `DEPTH`.
- In range: the array word at that index is captured into the response register at the acceptance edge. Loads issued after acceptance do not alter the in-flight response.
- Out of range (index ≥ `DEPTH`): the response is `in_mem=32'h0000_0000` with `in_mem_fault=1`.

**Outputs**
- `in_mem_busy` is 1 in WAIT and 0 in IDLE and RESP.
- `in_mem` holds its last value outside RESP; consumers qualify it with `in_mem_valid`.

**Preload**
- When `load_en=1` and `load_addr[31:2] < DEPTH`, `load_data` is written at the edge.
- Out-of-range loads are dropped silently.
- Loads are accepted in every state.
- A load and a fetch acceptance to the same word in the same cycle: the fetch returns the old word (read-before-write).

**Arithmetic**
- Only bits `[log2(DEPTH)+1:2]` index the array. The range check uses all of bits `[31:2]`, so the index never wraps.

## Timing

- A request accepted at edge N produces `in_mem_valid` high in the cycle after edge N+`LATENCY`, i.e. it is sampled by the requester at edge N+1+`LATENCY`.
- Throughput is one response per `LATENCY+1` cycles. With `LATENCY=0`, fetches run back-to-back at one per cycle.
- Reset values:
  - `in_mem=0`, `in_mem_valid=0`, `in_mem_busy=0`, `in_mem_fault=0`.
  - State IDLE, counter 0.
  - Array contents are not reset.
- Reset asserted mid-WAIT or mid-RESP aborts the request; no response follows reset release.
- `in_mem_en` asserted in the same cycle that reset deasserts is ignored. The first acceptance occurs at the first edge with `reset=1` sampled high beforehand.

## Configuration

- Macro: `IMEM_ALIGN_CHECK_EN`.
- **Defined:**
  - A fetch with `in_mem_addr[1:0]≠0` responds with data 0 and `in_mem_fault=1`, using normal latency.
  - A preload with `load_addr[1:0]≠0` is dropped.
- **Undefined:** address bits `[1:0]` are ignored on both ports, and misaligned accesses behave as the aligned word.

## Test plan

- **Preload and single fetch:** preload word 3 = `32'hDEAD_BEEF`, `LATENCY=2`, fetch `in_mem_addr=0x0C` at edge N → valid at N+3, `in_mem=32'hDEAD_BEEF`, fault 0, busy 1 at N+1..N+2.
- **Back-to-back at zero latency:** `LATENCY=0`, words 0..3 = 0x10..0x13, `in_mem_en` held high with addresses 0, 4, 8, 12 → four consecutive valid cycles returning 0x10..0x13.
- **Range fault:** `DEPTH=1024`, fetch `in_mem_addr=0x1000` → valid with `in_mem=0`, fault 1. A preload to 0x1000 leaves word 0 unchanged.
- **Capture at acceptance:** fetch word 5 (holding 0xAAAA_0005), then preload word 5 = 0x5555_0005 during WAIT → response is 0xAAAA_0005. The next fetch of word 5 returns 0x5555_0005.
- **Reset mid-flight:** reset pulled low during WAIT → all outputs 0 immediately. After release, no valid pulse until a new request.
- **Misalignment:** fetch 0x0E → with `IMEM_ALIGN_CHECK_EN` defined, data 0 and fault 1; without it, word 3 is returned with fault 0.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-memory fetch responder: word-addressed RAM with a preload port,
// answering fetch requests after LATENCY wait states with a valid/busy handshake.
// Optional build macro: IMEM_ALIGN_CHECK_EN (misaligned fetches fault, misaligned
// preloads are dropped). Without it, address bits [1:0] are ignored.
module imem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_mem_addr,
    input  logic        in_mem_en,
    output logic [31:0] in_mem,
    output logic        in_mem_valid,
    output logic        in_mem_busy,
    output logic        in_mem_fault,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    // state  | meaning
    // S_IDLE | no request in flight
    // S_WAIT | request accepted, counting down wait cycles
    // S_RESP | response presented for one cycle (in_mem_valid=1)
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam int          IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          LAT_M1   = (LATENCY > 0) ? LATENCY - 1 : 0;
    localparam logic [3:0]  CNT_LOAD = 4'(LAT_M1);

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic [3:0]  wait_cnt;
    logic [31:0] mem [DEPTH];
    logic [31:0] resp_data;
    logic        resp_fault;

    logic [IW-1:0] fetch_idx;
    logic [IW-1:0] load_idx;
    logic          fetch_in_range;
    logic          load_in_range;
    logic          fetch_misalign;
    logic          load_misalign;
    logic          fetch_fault;
    logic          load_ok;
    logic [31:0]   fetch_word;

    assign fetch_idx = in_mem_addr[IW+1:2];
    assign load_idx  = load_addr[IW+1:2];

    // Range checks use the full word index so high addresses never alias low words.
    assign fetch_in_range = ({2'b00, in_mem_addr[31:2]} < $unsigned(DEPTH));
    assign load_in_range  = ({2'b00, load_addr[31:2]} < $unsigned(DEPTH));

`ifdef IMEM_ALIGN_CHECK_EN
    assign fetch_misalign = (in_mem_addr[1:0] != 2'b00);
    assign load_misalign  = (load_addr[1:0] != 2'b00);
`else
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{in_mem_addr[1:0], load_addr[1:0]};
    assign fetch_misalign   = 1'b0;
    assign load_misalign    = 1'b0;
`endif

    assign fetch_fault = !fetch_in_range || fetch_misalign;
    assign load_ok     = load_en && load_in_range && !load_misalign;
    assign fetch_word  = fetch_fault ? 32'h0000_0000 : mem[fetch_idx];

    assign in_mem_valid = (state == S_RESP);
    assign in_mem_busy  = (state == S_WAIT);
    assign in_mem_fault = (state == S_RESP) && resp_fault;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode; requests are only taken in IDLE or RESP.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            S_IDLE, S_RESP: begin
                if (in_mem_en) begin
                    accept    = 1'b1;
                    state_nxt = (LATENCY > 0) ? S_WAIT : S_RESP;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0) state_nxt = S_RESP;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Wait counter, capture at acceptance, and output word update on entry to RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt   <= 4'd0;
            resp_data  <= 32'h0000_0000;
            resp_fault <= 1'b0;
            in_mem     <= 32'h0000_0000;
        end else begin
            if (accept) begin
                wait_cnt   <= CNT_LOAD;
                resp_data  <= fetch_word;
                resp_fault <= fetch_fault;
            end else if (state == S_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            if (accept && LATENCY == 0) begin
                in_mem <= fetch_word;
            end else if (state == S_WAIT && wait_cnt == 4'd0) begin
                in_mem <= resp_data;
            end
        end
    end

    // Preload write port; the fetch path samples the old word on a same-edge collision.
    always_ff @(posedge clk) begin
        if (load_ok) mem[load_idx] <= load_data;
    end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: one instance with LATENCY=2 and one with LATENCY=0,
// a shadow memory per instance, and a response scoreboard per instance.
module tb_imem_responder;

    typedef struct packed {
        logic [31:0] data;
        logic        fault;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic [31:0] addr2 = '0, ld_addr2 = '0, ld_data2 = '0, in_mem2;
    logic        en2 = 1'b0, ld_en2 = 1'b0, valid2, busy2, fault2;
    logic [31:0] addr0 = '0, ld_addr0 = '0, ld_data0 = '0, in_mem0;
    logic        en0 = 1'b0, ld_en0 = 1'b0, valid0, busy0, fault0;

    bit [31:0] m2 [1024];
    bit [31:0] m0 [1024];
    resp_t     q2 [$];
    resp_t     q0 [$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    imem_responder #(.DEPTH(1024), .LATENCY(2)) dut2 (
        .clk(clk), .reset(reset),
        .in_mem_addr(addr2), .in_mem_en(en2),
        .in_mem(in_mem2), .in_mem_valid(valid2), .in_mem_busy(busy2), .in_mem_fault(fault2),
        .load_en(ld_en2), .load_addr(ld_addr2), .load_data(ld_data2)
    );

    imem_responder #(.DEPTH(1024), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset),
        .in_mem_addr(addr0), .in_mem_en(en0),
        .in_mem(in_mem0), .in_mem_valid(valid0), .in_mem_busy(busy0), .in_mem_fault(fault0),
        .load_en(ld_en0), .load_addr(ld_addr0), .load_data(ld_data0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic resp_t model_resp(input logic [31:0] a, input logic [31:0] w);
        resp_t r;
        r.data  = w;
        r.fault = 1'b0;
        if (a[31:2] >= 30'd1024) begin
            r.data  = 32'h0;
            r.fault = 1'b1;
        end
`ifdef IMEM_ALIGN_CHECK_EN
        if (a[1:0] != 2'b00) begin
            r.data  = 32'h0;
            r.fault = 1'b1;
        end
`endif
        return r;
    endfunction

    function automatic bit load_accepted(input logic [31:0] a);
        bit ok;
        ok = (a[31:2] < 30'd1024);
`ifdef IMEM_ALIGN_CHECK_EN
        if (a[1:0] != 2'b00) ok = 1'b0;
`endif
        return ok;
    endfunction

    // Scoreboard: every valid pulse pops one expected response.
    always @(negedge clk) begin
        resp_t e;
        if (reset) begin
            if (valid2) begin
                if (q2.size() == 0) chk("spurious_valid2", {31'b0, valid2}, 32'd0);
                else begin
                    e = q2.pop_front();
                    chk("data2", in_mem2, e.data);
                    chk("fault2", {31'b0, fault2}, {31'b0, e.fault});
                end
            end
            if (valid0) begin
                if (q0.size() == 0) chk("spurious_valid0", {31'b0, valid0}, 32'd0);
                else begin
                    e = q0.pop_front();
                    chk("data0", in_mem0, e.data);
                    chk("fault0", {31'b0, fault0}, {31'b0, e.fault});
                end
            end
            if (fault2 && !valid2) chk("fault2_without_valid", {31'b0, fault2}, 32'd0);
            if (fault0 && !valid0) chk("fault0_without_valid", {31'b0, fault0}, 32'd0);
        end
    end

    task automatic load_word(input int sel, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        if (sel == 0) begin
            ld_en0 = 1'b1; ld_addr0 = a; ld_data0 = d;
            if (load_accepted(a)) m0[a[11:2]] = d;
        end else begin
            ld_en2 = 1'b1; ld_addr2 = a; ld_data2 = d;
            if (load_accepted(a)) m2[a[11:2]] = d;
        end
        @(negedge clk);
        ld_en0 = 1'b0;
        ld_en2 = 1'b0;
    endtask

    // Drive one request on the LATENCY=2 instance; returns at the negedge after acceptance.
    task automatic issue2(input logic [31:0] a);
        @(negedge clk);
        en2   = 1'b1;
        addr2 = a;
        q2.push_back(model_resp(a, m2[a[11:2]]));
        @(negedge clk);
        en2 = 1'b0;
    endtask

    // Called at the first negedge after acceptance; expects valid on the third.
    task automatic wait2();
        int  n;
        bit  got;
        n   = 1;
        got = 1'b0;
        while (n <= 20 && !got) begin
            if (n > 1) @(negedge clk);
            if (valid2) got = 1'b1;
            else begin
                chk("busy_while_waiting", {31'b0, busy2}, 32'd1);
                n++;
            end
        end
        chk("response_seen", {31'b0, got}, 32'd1);
        if (got) begin
            chk("latency2", 32'(n), 32'd3);
            chk("busy_in_resp", {31'b0, busy2}, 32'd0);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_mem", in_mem2, 32'h0);
        chk("rst_valid", {31'b0, valid2}, 32'd0);
        chk("rst_busy", {31'b0, busy2}, 32'd0);
        chk("rst_fault", {31'b0, fault2}, 32'd0);
        reset = 1'b1;

        // Preload and single fetch
        load_word(2, 32'h0000_0000, 32'h0000_1111);
        load_word(2, 32'h0000_000C, 32'hDEAD_BEEF);
        issue2(32'h0000_000C);
        wait2();

        // Range fault, including an index that would wrap if truncated
        issue2(32'h0000_1000);
        wait2();
        issue2(32'hFFFF_FFFC);
        wait2();
        load_word(2, 32'h0000_1000, 32'h0BAD_0BAD);
        issue2(32'h0000_0000);
        wait2();

        // Capture at acceptance: load during WAIT does not alter the in-flight word
        load_word(2, 32'h0000_0014, 32'hAAAA_0005);
        issue2(32'h0000_0014);
        ld_en2 = 1'b1; ld_addr2 = 32'h0000_0014; ld_data2 = 32'h5555_0005;
        m2[5] = 32'h5555_0005;
        wait2();
        ld_en2 = 1'b0;
        issue2(32'h0000_0014);
        wait2();

        // Same-edge load and fetch of one word returns the old word
        @(negedge clk);
        en2 = 1'b1; addr2 = 32'h0000_0014;
        q2.push_back(model_resp(32'h0000_0014, m2[5]));
        ld_en2 = 1'b1; ld_addr2 = 32'h0000_0014; ld_data2 = 32'h7777_0005;
        m2[5] = 32'h7777_0005;
        @(negedge clk);
        en2 = 1'b0; ld_en2 = 1'b0;
        wait2();
        issue2(32'h0000_0014);
        wait2();

        // Misaligned fetch
        issue2(32'h0000_000E);
        wait2();

        // Back-to-back at zero latency
        for (int i = 0; i < 4; i++) load_word(0, 32'(i * 4), 32'(32'h10 + i));
        @(negedge clk);
        en0 = 1'b1; addr0 = 32'h0;
        q0.push_back(model_resp(32'h0, m0[0]));
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("b2b_valid", {31'b0, valid0}, 32'd1);
            chk("b2b_busy", {31'b0, busy0}, 32'd0);
            if (i < 4) begin
                addr0 = 32'(i * 4);
                q0.push_back(model_resp(addr0, m0[i]));
            end else begin
                en0 = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b_end_valid", {31'b0, valid0}, 32'd0);

        // Reset mid-flight: outputs clear at once and nothing follows release
        issue2(32'h0000_000C);
        chk("pre_reset_busy", {31'b0, busy2}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_in_mem", in_mem2, 32'h0);
        chk("mid_rst_valid", {31'b0, valid2}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy2}, 32'd0);
        chk("mid_rst_fault", {31'b0, fault2}, 32'd0);
        q2.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_valid", {31'b0, valid2}, 32'd0);
        end
        issue2(32'h0000_000C);
        wait2();

        repeat (3) @(negedge clk);
        chk("q2_drained", 32'(q2.size()), 32'd0);
        chk("q0_drained", 32'(q0.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
